// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DIVZERO,
        RUN,
        DONE
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] partial_rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The partial remainder is always below the divisor, so the true
    // difference fits in WIDTH bits and the modular subtraction is exact.
    always_comb begin
        shifted  = {partial_rem, in_bit};
        diff     = shifted[WIDTH-1:0] - divisor;
        q_bit    = (shifted >= {1'b0, divisor});
        next_rem = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS32 DIV/DIVU.
// result_o = {remainder, quotient}; signed results truncate toward zero and
// the remainder takes the dividend's sign. A zero divisor yields zero.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               cancel_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state;
    div_state_e       next_state;
    logic [CNT_W-1:0] count;

    // Operand latches; dvd_q shifts dividend bits out the top while
    // quotient bits shift in at the bottom.
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             sgn;
    logic             dvd_neg;
    logic             dvs_neg;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             accept;
    logic             finish_run;
    logic             finish_zero;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                                input logic             neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_rem (rem),
        .in_bit      (dvd_q[WIDTH-1]),
        .divisor     (dvs),
        .next_rem    (step_rem),
        .q_bit       (step_q)
    );

    assign quot_next   = {dvd_q[WIDTH-2:0], step_q};
    assign quot_fix    = neg_if(quot_next, sgn && (dvd_neg ^ dvs_neg));
    assign rem_fix     = neg_if(step_rem, sgn && dvd_neg);
    assign accept      = (state == IDLE) && (next_state == RUN);
    assign finish_run  = (state == RUN) && (next_state == DONE);
    assign finish_zero = (state == DIVZERO) && (next_state == DONE);

    assign busy_o  = (state == RUN) || (state == DIVZERO);
    assign ready_o = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; cancel beats everything except reset.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cancel_i) begin
                    next_state = IDLE;
                end else if (start_i) begin
                    next_state = (divisor_i == '0) ? DIVZERO : RUN;
                end
            end
            DIVZERO: next_state = cancel_i ? IDLE : DONE;
            RUN: begin
                if (cancel_i) begin
                    next_state = IDLE;
                end else if (count == LAST_CNT) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Iteration counter and result register; result_o only changes when a
    // divide completes, so cancel leaves the previous result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            result_o <= '0;
        end else begin
            if (accept) begin
                count <= '0;
            end else if (state == RUN && !cancel_i) begin
                count <= count + 1'b1;
            end
            if (finish_run) begin
                result_o <= {rem_fix, quot_fix};
            end else if (finish_zero) begin
                result_o <= '0;
            end
        end
    end

    // Datapath: latch magnitudes on acceptance, then one restoring step per
    // RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_q   <= abs_val(dividend_i, signed_i);
            dvs     <= abs_val(divisor_i, signed_i);
            rem     <= '0;
            sgn     <= signed_i;
            dvd_neg <= dividend_i[WIDTH-1];
            dvs_neg <= divisor_i[WIDTH-1];
        end else if (state == RUN) begin
            rem   <= step_rem;
            dvd_q <= quot_next;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        cancel_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .cancel_i   (cancel_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o)
    );

    // Reference: plain 64-bit arithmetic (truncating division, remainder
    // follows the dividend sign), zero result for a zero divisor.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint x;
        longint y;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle (cycle c); returns in cycle c+1.
    task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        signed_i   = 1'($urandom);
    endtask

    // Returns the cycle offset from c at which ready_o was seen (bounded).
    task automatic wait_ready(output int cyc);
        cyc = 1;
        while (!ready_o && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_check(input string tag, input logic sgn, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp);
        int cyc;
        start_div(sgn, a, b);
        wait_ready(cyc);
        chk({tag, "_lat"}, 64'(cyc), (b == 32'd0) ? 64'd2 : 64'd33);
        chk({tag, "_res"}, result_o, exp);
        tick();
        chk({tag, "_idle"}, {62'd0, busy_o, ready_o}, 64'd0);
    endtask

    initial begin
        int          good;
        int          pulses;
        int          pulse_at;
        int          cyc;
        logic [63:0] prev;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        int          sel;

        rst        = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        cancel_i   = 1'b0;
        tick();
        tick();
        chk("rst_result", result_o, 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        rst = 1'b0;
        tick();

        // DIVU 100/7 with cycle-by-cycle busy/ready tracking.
        start_div(1'b0, 32'd100, 32'd7);
        good = 0;
        for (int k = 1; k <= 32; k++) begin
            if (busy_o && !ready_o) good++;
            tick();
        end
        chk("divu100_busy_cycles", 64'(good), 64'd32);
        chk("divu100_ready_c33", 64'(ready_o), 64'd1);
        chk("divu100_busy_c33", 64'(busy_o), 64'd0);
        chk("divu100_res", result_o, 64'h00000002_0000000E);
        tick();
        chk("divu100_ready_c34", 64'(ready_o), 64'd0);

        run_check("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_check("divu_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC);
        run_check("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_check("divu_max", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
        run_check("div_by0", 1'b1, 32'h12345678, 32'd0, 64'd0);
        run_check("divu100b", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        run_check("divu_by0", 1'b0, 32'hDEADBEEF, 32'd0, 64'd0);

        // Cancel in the 10th RUN cycle.
        run_check("pre_cancel", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        prev = result_o;
        start_div(1'b0, 32'd1000, 32'd3);
        for (int k = 1; k < 10; k++) tick();
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        chk("cancel_busy", 64'(busy_o), 64'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (ready_o) pulses++;
            tick();
        end
        chk("cancel_no_ready", 64'(pulses), 64'd0);
        chk("cancel_keep_res", result_o, prev);
        run_check("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // Cancel and start together in IDLE: nothing accepted.
        signed_i  = 1'b0;
        divisor_i = 32'd5;
        start_i   = 1'b1;
        cancel_i  = 1'b1;
        tick();
        start_i   = 1'b0;
        cancel_i  = 1'b0;
        chk("cancel_start_idle", {62'd0, busy_o, ready_o}, 64'd0);

        // Reset in the middle of RUN.
        start_div(1'b1, 32'hFFFFFF00, 32'd7);
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_ready", 64'(ready_o), 64'd0);
        chk("midrst_result", result_o, 64'd0);
        rst = 1'b0;
        tick();

        // start_i held high through DONE.
        signed_i   = 1'b0;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        start_i    = 1'b1;
        tick();
        pulses   = 0;
        pulse_at = 0;
        for (int k = 1; k <= 33; k++) begin
            if (ready_o) begin
                pulses++;
                pulse_at = k;
            end
            tick();
        end
        chk("hold_pulses", 64'(pulses), 64'd1);
        chk("hold_pulse_at", 64'(pulse_at), 64'd33);
        chk("hold_idle_c34", {62'd0, busy_o, ready_o}, 64'd0);
        chk("hold_res", result_o, 64'h00000002_0000000E);
        tick();
        start_i = 1'b0;
        chk("hold_restart_busy", 64'(busy_o), 64'd1);
        cancel_i = 1'b1;
        tick();
        cancel_i = 1'b0;
        chk("hold_cancel_idle", 64'(busy_o), 64'd0);

        // Randomized operands against the model.
        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 7));
            a   = $urandom;
            sgn = 1'($urandom);
            if (sel == 0)      b = 32'd0;
            else if (sel == 1) b = 32'($urandom_range(1, 15));
            else if (sel == 2) b = 32'hFFFFFFFF;
            else               b = $urandom;
            if (sel == 3) a = 32'($urandom_range(0, 100));
            start_div(sgn, a, b);
            wait_ready(cyc);
            chk($sformatf("rnd%0d_lat", i), 64'(cyc), (b == 32'd0) ? 64'd2 : 64'd33);
            chk($sformatf("rnd%0d_res", i), result_o, model(sgn, a, b));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
